// File: rtl/cart_bus_master.sv
// cart_bus_master: single-access cartridge bus master. Each accepted request runs the
// sequence SETUP -> STROBE -> HOLD -> DONE with parameterized phase lengths, drives the
// cartridge control/address/data banks, and returns a one-cycle rsp_valid pulse.
//
// Optional feature: define CART_BUS_RDSYNC_EN to route cart_tran_bank1_in through a
// two-flop synchronizer; read strobes are then stretched by 2 cycles so the sampled
// value has crossed the synchronizer. Writes are unaffected.
//
// Ports:
//   clk_sys              sole clock, rising edge
//   reset                synchronous, active-high
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_addr/we/wdata    request payload, latched on acceptance
//   rsp_valid/rsp_rdata  completion pulse and last read data
//   cart_tran_bank0_out  {cart_nRESET, nCS, nRD, nWR}
//   cart_tran_bank1_*    data bus in/out and direction (1 = FPGA drives)
//   cart_tran_bank2_out  A[15:8]
//   cart_tran_bank3_out  A[7:0]
module cart_bus_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [7:4]  cart_tran_bank0_out,
    input  logic [7:0]  cart_tran_bank1_in,
    output logic [7:0]  cart_tran_bank1_out,
    output logic        cart_tran_bank1_dir,
    output logic [7:0]  cart_tran_bank2_out,
    output logic [7:0]  cart_tran_bank3_out
);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_t;

    // Counters load "length - 1" on state entry and leave the state at zero.
    localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;

    logic [7:0]  bus_in;
    logic        strobe_end;
    logic        accept;
    logic        sample;

`ifdef CART_BUS_RDSYNC_EN
    logic [1:0] ext_q, ext_d;
    logic [7:0] sync1_q, sync2_q;

    assign bus_in     = sync2_q;
    assign strobe_end = (cnt_q == 4'd0) && (ext_q == 2'd0);

    // Extension is armed on the last SETUP cycle for reads; it burns down once the
    // nominal strobe counter has reached zero.
    always_comb begin
        ext_d = ext_q;
        if (state_q == StSetup && cnt_q == 4'd0) begin
            ext_d = we_q ? 2'd0 : 2'd2;
        end else if (state_q == StStrobe && cnt_q == 4'd0 && ext_q != 2'd0) begin
            ext_d = ext_q - 2'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext_q   <= 2'd0;
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            ext_q   <= ext_d;
            sync1_q <= cart_tran_bank1_in;
            sync2_q <= sync1_q;
        end
    end
`else
    assign bus_in     = cart_tran_bank1_in;
    assign strobe_end = (cnt_q == 4'd0);
`endif

    assign accept = (state_q == StIdle) && req_valid;
    assign sample = (state_q == StStrobe) && strobe_end && !we_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StSetup;
                    cnt_d   = SetupLd;
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStrobe: begin
                if (strobe_end) begin
                    state_d = StHold;
                    cnt_d   = HoldLd;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (sample) begin
                rdata_q <= bus_in;
            end
        end
    end

    // Outputs are forced to their reset values combinationally so the bus is
    // released for the whole time reset is held, not just after the reset edge.
    logic active;
    logic drive;
    logic n_cs, n_rd, n_wr;

    always_comb begin
        active = (state_q == StSetup) || (state_q == StStrobe);
        drive  = we_q && (active || state_q == StHold);
        n_cs   = !(active && addr_q[15:13] == 3'b101);
        n_rd   = !(active && !we_q);
        n_wr   = !(state_q == StStrobe && we_q);

        req_ready           = !reset && (state_q == StIdle);
        rsp_valid           = !reset && (state_q == StDone);
        rsp_rdata           = reset ? 8'h00 : rdata_q;
        cart_tran_bank0_out = reset ? 4'b1111 : {1'b1, n_cs, n_rd, n_wr};
        cart_tran_bank1_dir = !reset && drive;
        cart_tran_bank1_out = (!reset && drive) ? wdata_q : 8'h00;
        cart_tran_bank2_out = reset ? 8'h00 : addr_q[15:8];
        cart_tran_bank3_out = reset ? 8'h00 : addr_q[7:0];
    end

endmodule

// File: tb/tb_cart_bus_master.sv
// tb_cart_bus_master: directed plus randomized accesses against a cycle-position model
// of the cartridge bus protocol (phase windows computed from the phase lengths).
module tb_cart_bus_master;

    localparam int SetupCyc  = 2;
    localparam int StrobeCyc = 4;
    localparam int HoldCyc   = 1;
`ifdef CART_BUS_RDSYNC_EN
    localparam int RdExt = 2;
`else
    localparam int RdExt = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [7:4]  bank0;
    logic [7:0]  bank1_in;
    logic [7:0]  bank1_out;
    logic        bank1_dir;
    logic [7:0]  bank2;
    logic [7:0]  bank3;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  model_rdata = 8'h00;

    always #5 clk_sys = ~clk_sys;

    cart_bus_master #(
        .SETUP_CYC (SetupCyc),
        .STROBE_CYC(StrobeCyc),
        .HOLD_CYC  (HoldCyc)
    ) dut (
        .clk_sys            (clk_sys),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_addr           (req_addr),
        .req_we             (req_we),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .cart_tran_bank0_out(bank0),
        .cart_tran_bank1_in (bank1_in),
        .cart_tran_bank1_out(bank1_out),
        .cart_tran_bank1_dir(bank1_dir),
        .cart_tran_bank2_out(bank2),
        .cart_tran_bank3_out(bank3)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk1({tag, "_ready"}, req_ready, 1'b0);
        chk1({tag, "_valid"}, rsp_valid, 1'b0);
        chk8({tag, "_rdata"}, rsp_rdata, 8'h00);
        chk4({tag, "_bank0"}, bank0, 4'b1111);
        chk8({tag, "_bank1"}, bank1_out, 8'h00);
        chk1({tag, "_dir"}, bank1_dir, 1'b0);
        chk8({tag, "_bank2"}, bank2, 8'h00);
        chk8({tag, "_bank3"}, bank3, 8'h00);
    endtask

    // Called at a falling edge while idle; returns at the falling edge of the first
    // idle cycle after DONE. While busy, req_* carry junk that must be ignored.
    task automatic run_txn(input logic [15:0] a, input logic we, input logic [7:0] wd,
                           input logic [7:0] bus);
        int   s_end, st_end, h_end, t;
        logic setup, strobe, hold, done, drive;
        s_end  = SetupCyc;
        st_end = s_end + StrobeCyc + (we ? 0 : RdExt);
        h_end  = st_end + HoldCyc;
        t      = h_end + 1;
        chk1("ready_pre", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        bank1_in  = bus;
        @(posedge clk_sys);
        #1;
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_we    = 1'($urandom_range(0, 1));
        req_wdata = 8'($urandom);
        for (int j = 1; j <= t + 1; j++) begin
            @(negedge clk_sys);
            setup  = (j <= s_end);
            strobe = (j > s_end) && (j <= st_end);
            hold   = (j > st_end) && (j <= h_end);
            done   = (j == t);
            drive  = we && (setup || strobe || hold);
            chk1("req_ready", req_ready, j == t + 1);
            chk1("rsp_valid", rsp_valid, done);
            chk4("bank0", bank0, {1'b1, !((setup || strobe) && a[15:13] == 3'b101),
                                  !(!we && (setup || strobe)), !(we && strobe)});
            chk1("bank1_dir", bank1_dir, drive);
            chk8("bank1_out", bank1_out, drive ? wd : 8'h00);
            chk8("bank2", bank2, a[15:8]);
            chk8("bank3", bank3, a[7:0]);
            if (done) begin
                if (!we) model_rdata = bus;
                chk8("rsp_rdata", rsp_rdata, model_rdata);
            end
            if (j == t) req_valid = 1'b0;
        end
        chk8("rdata_idle", rsp_rdata, model_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pulses;
        int pc[3];
        logic [15:0] ra;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_we    = 1'b0;
        req_wdata = 8'h00;
        bank1_in  = 8'h00;
        repeat (3) begin
            @(negedge clk_sys);
            chk_rst("rst_init");
        end
        reset = 1'b0;
        @(negedge clk_sys);
        chk1("ready_after_rst", req_ready, 1'b1);
        chk4("bank0_after_rst", bank0, 4'b1111);
        chk1("valid_after_rst", rsp_valid, 1'b0);

        // Directed accesses.
        run_txn(16'h0150, 1'b0, 8'h00, 8'h3C);
        run_txn(16'h2000, 1'b1, 8'h05, 8'h5A);
        run_txn(16'hA010, 1'b0, 8'h00, 8'h81);
        run_txn(16'h4000, 1'b0, 8'h00, 8'hE7);
        run_txn(16'hBFFF, 1'b1, 8'hC3, 8'h11);
        run_txn(16'hC000, 1'b0, 8'h00, 8'h00);

        // Randomized accesses, biased toward the chip-select window.
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ra[15:13] = 3'b101;
            run_txn(ra, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        // req_valid held high across three writes: three pulses, 9 cycles apart.
        acc       = 0;
        pulses    = 0;
        pc        = '{0, 0, 0};
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h1234;
        req_wdata = 8'h77;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin
                if (pulses < 3) pc[pulses] = i;
                pulses++;
            end
            if (req_ready && req_valid) acc++;
            if (acc == 3 && req_valid) begin
                @(posedge clk_sys);
                #1;
                req_valid = 1'b0;
            end
            @(negedge clk_sys);
        end
        chkint("b2b_pulses", pulses, 3);
        chkint("b2b_gap01", pc[1] - pc[0], 9);
        chkint("b2b_gap12", pc[2] - pc[1], 9);
        chk8("b2b_rdata", rsp_rdata, model_rdata);

        // Reset asserted in cycle N+4 of a write aborts it.
        chk1("abort_ready_pre", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'hA100;
        req_wdata = 8'h3E;
        @(posedge clk_sys);
        #1;
        req_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk_sys);
            chk1("abort_dir", bank1_dir, 1'b1);
            chk4("abort_bank0", bank0, {1'b1, 1'b0, 1'b1, (j >= 3) ? 1'b0 : 1'b1});
        end
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        chk_rst("rst_mid");
        @(negedge clk_sys);
        chk_rst("rst_after_edge");
        reset       = 1'b0;
        model_rdata = 8'h00;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_sys);
            chk1("abort_no_valid", rsp_valid, 1'b0);
            chk1("abort_ready", req_ready, 1'b1);
            chk4("abort_idle_bank0", bank0, 4'b1111);
        end

        // Recovery after abort.
        run_txn(16'hA5A5, 1'b0, 8'h00, 8'h96);
        run_txn(16'h0001, 1'b1, 8'h42, 8'h24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
